// File: rtl/serial_alu.sv
`default_nettype none
// ============================================================================
// serial_alu : LSB-first bit-serial ALU with START/DONE handshake.
// Optional macro SERIAL_ALU_COMPARE_EN enables SLT (OP 110) / SLTU (OP 111).
// Revision : 1.0
// ============================================================================
module serial_alu #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             CARRY,
  output logic             ZERO
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zacc_q, zacc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cy_q, cy_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic             b_bit, sum_bit, cout_bit, r_bit;
  logic [WIDTH-1:0] res_next;

  function automatic logic inv_b(input logic [2:0] op);
`ifdef SERIAL_ALU_COMPARE_EN
    return (op == 3'b001) || (op[2:1] == 2'b11);
`else
    return (op == 3'b001);
`endif
  endfunction

  // One full-adder slice plus the gate-level logic ops on the current LSBs.
  always_comb begin
    b_bit    = b_q[0] ^ inv_b(op_q);
    sum_bit  = a_q[0] ^ b_bit ^ carry_q;
    cout_bit = (a_q[0] & b_bit) | (carry_q & (a_q[0] ^ b_bit));
    case (op_q)
      3'b000, 3'b001: r_bit = sum_bit;
      3'b010:         r_bit = a_q[0] & b_q[0];
      3'b011:         r_bit = a_q[0] | b_q[0];
      3'b100:         r_bit = a_q[0] ^ b_q[0];
      3'b101:         r_bit = ~(a_q[0] | b_q[0]);
      default:        r_bit = 1'b0;
    endcase
    res_next = {r_bit, res_q};
  end

`ifdef SERIAL_ALU_COMPARE_EN
  logic lt_bit;
  // On the final bit a_q[0]/b_q[0] hold the operand sign bits.
  assign lt_bit = op_q[0] ? ~cout_bit
                          : ((a_q[0] != b_q[0]) ? a_q[0] : sum_bit);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zacc_d  = zacc_q;
    res_d   = res_q;
    y_d     = y_q;
    cy_d    = cy_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = A;
          b_d     = B;
          op_d    = OP;
          cnt_d   = '0;
          carry_d = inv_b(OP);
          zacc_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = res_next[WIDTH-1:1];
        carry_d = cout_bit;
        zacc_d  = zacc_q & ~r_bit;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          y_d     = res_next;
          cy_d    = (op_q[2:1] == 2'b00) ? cout_bit : 1'b0;
          zero_d  = zacc_q & ~r_bit;
`ifdef SERIAL_ALU_COMPARE_EN
          if (op_q[2:1] == 2'b11) begin
            y_d    = {{(WIDTH-1){1'b0}}, lt_bit};
            zero_d = ~lt_bit;
          end
`endif
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      y_q     <= '0;
      cy_q    <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zacc_q  <= zacc_d;
      y_q     <= y_d;
      cy_q    <= cy_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign BUSY  = (state_q == RUN);
  assign DONE  = done_q;
  assign Y     = y_q;
  assign CARRY = cy_q;
  assign ZERO  = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_alu.sv
`default_nettype none
// ============================================================================
// tb_serial_alu : randomized scoreboard bench for serial_alu (WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_serial_alu;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             RST, START;
  logic [2:0]       OP;
  logic [WIDTH-1:0] A, B, Y;
  logic             BUSY, DONE, CARRY, ZERO;

  serial_alu #(.WIDTH(WIDTH)) dut (
    .CLK(clk), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .Y(Y), .CARRY(CARRY), .ZERO(ZERO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             c;
    logic             z;
    int               due;
  } exp_t;

  exp_t             sb[$];
  int               cyc = 0;
  logic             rst_at_edge = 1'b0;
  bit               mon_en = 1'b0;
  int               errors = 0;
  int               checks = 0;
  logic [WIDTH-1:0] hold_y = '0;
  logic             hold_c = 1'b0;
  logic             hold_z = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on whole operands.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] op);
    exp_t         e;
    logic [WIDTH:0] wide;
    e.y = '0;
    e.c = 1'b0;
    e.due = 0;
    case (op)
      3'd0: begin wide = {1'b0, a} + {1'b0, b}; e.y = wide[WIDTH-1:0]; e.c = wide[WIDTH]; end
      3'd1: begin e.y = a - b; e.c = (a >= b); end
      3'd2: e.y = a & b;
      3'd3: e.y = a | b;
      3'd4: e.y = a ^ b;
      3'd5: e.y = ~(a | b);
`ifdef SERIAL_ALU_COMPARE_EN
      3'd6: e.y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'd7: e.y = {{(WIDTH-1){1'b0}}, (a < b)};
`endif
      default: e.y = '0;
    endcase
    e.z = (e.y == '0);
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
    rst_at_edge = RST;
  end

  initial begin : monitor
    logic exp_busy;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_busy = (sb.size() > 0) && (cyc >= sb[0].due - WIDTH) && (cyc < sb[0].due);
        chk("busy", 32'(BUSY), 32'(exp_busy));
        if (rst_at_edge) begin
          hold_y = '0;
          hold_c = 1'b0;
          hold_z = 1'b0;
          chk("done_in_reset", 32'(DONE), 32'(0));
        end else if (DONE) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got DONE=1 expected DONE=0 (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.due));
            hold_y = e.y;
            hold_c = e.c;
            hold_z = e.z;
          end
        end else if (sb.size() > 0 && cyc >= sb[0].due) begin
          checks++;
          errors++;
          $display("FAIL missing_done: got DONE=0 expected DONE=1 (cycle %0d)", cyc);
          e = sb.pop_front();
          hold_y = e.y;
          hold_c = e.c;
          hold_z = e.z;
        end
        chk("y", 32'(Y), 32'(hold_y));
        chk("carry", 32'(CARRY), 32'(hold_c));
        chk("zero", 32'(ZERO), 32'(hold_z));
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
    exp_t e;
    int   g = 0;
    while (BUSY && g < 40) begin
      step(1);
      g++;
    end
    if (BUSY) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got BUSY=1 expected BUSY=0 (cycle %0d)", cyc);
    end
    A = a;
    B = b;
    OP = op;
    START = 1'b1;
    e = model(a, b, op);
    e.due = cyc + 1 + WIDTH;
    sb.push_back(e);
    step(1);
    START = 1'b0;
    A = WIDTH'($urandom);
    B = WIDTH'($urandom);
    OP = 3'($urandom);
  endtask

  task automatic wait_done();
    int g = 0;
    while (!DONE && g < 40) begin
      step(1);
      g++;
    end
    if (!DONE) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: got DONE=0 expected DONE=1 (cycle %0d)", cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    RST = 1'b1;
    START = 1'b1;
    A = 8'hF0;
    B = 8'h25;
    OP = 3'b000;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1);
    RST = 1'b0;
    START = 1'b0;
    step(2);

    // Directed operations from the block's intended use.
    issue(8'hF0, 8'h25, 3'b000);
    issue(8'h42, 8'h42, 3'b001);
    issue(8'h0F, 8'h30, 3'b101);
    issue(8'h10, 8'h20, 3'b001);
    issue(8'hFE, 8'h01, 3'b110);
    issue(8'hFE, 8'h01, 3'b111);
    issue(8'h01, 8'hFE, 3'b110);
    issue(8'h00, 8'h00, 3'b010);

    // START mid-run is ignored; then START in the DONE cycle chains back-to-back.
    issue(8'h33, 8'h44, 3'b000);
    step(3);
    START = 1'b1;
    A = 8'hAA;
    B = 8'h55;
    OP = 3'b011;
    step(1);
    START = 1'b0;
    wait_done();
    issue(8'hC3, 8'h3C, 3'b100);

    // Abort at bit 4, then a clean rerun.
    issue(8'h01, 8'h01, 3'b000);
    step(4);
    RST = 1'b1;
    step(1);
    sb.delete();
    RST = 1'b0;
    step(WIDTH + 2);
    issue(8'h01, 8'h01, 3'b000);

    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? ra : WIDTH'($urandom);
      issue(ra, rb, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 4) == 0) begin
        step(2);
        START = 1'b1;
        step(1);
        START = 1'b0;
      end else begin
        step($urandom_range(0, 2));
      end
    end

    g = 0;
    while (sb.size() > 0 && g < 40) begin
      step(1);
      g++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Bit-serial ALU datapath stage for the RV523 core. It consumes a pair of register operands, processes them LSB-first at one bit per clock, and hands a parallel result to the writeback stage.
- The per-bit logic maps directly onto the cell library: NOR/NAND gates, a full-adder slice and one carry flip-flop. This keeps the transistor count minimal at the cost of WIDTH-cycle latency.
- A START/DONE handshake lets the sequencer stall while an operation is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; minimum 2.

Ports:
- CLK  input  1  single system clock; all state changes on its rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request a new operation; sampled only when BUSY=0.
- OP  input  3  operation select, captured with START.
- A  input  WIDTH  operand A, captured with START.
- B  input  WIDTH  operand B, captured with START.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse; Y, CARRY and ZERO are valid and stable from this cycle on.
- Y  output  WIDTH  result; held until the next completion.
- CARRY  output  1  final carry-out for ADD/SUB (SUB: 1 = no borrow); 0 for all other ops.
- ZERO  output  1  Y == 0, accumulated serially.

Behaviour:
- Reset: RST high at a rising edge of CLK forces state IDLE and BUSY=0, DONE=0, Y=0, CARRY=0, ZERO=0. The carry flip-flop, bit counter and operand shift registers are cleared. RST has priority over START.
- Reset mid-operation aborts the operation: no DONE pulse, Y=0.
- States: IDLE, RUN.
- IDLE: if START=1 at an edge, capture A, B and OP, clear the counter, preset the carry, and go to RUN. BUSY=1 from the next cycle.
- RUN: each edge processes bit i (i = 0..WIDTH-1):
  - shift A and B right by one;
  - shift the result bit into the MSB of the result shift register;
  - update the carry flip-flop and the zero accumulator.
- On the edge that processes bit WIDTH-1:
  - transfer the result register to Y, and load CARRY and ZERO;
  - pulse DONE=1 for exactly the following cycle, with BUSY=0 in that cycle;
  - return to IDLE.
- Latency: START sampled at edge k -> DONE high in the cycle after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- START while BUSY=1 is ignored; captured operands are not disturbed and no request is queued.
- START=1 during the DONE cycle is accepted (state is IDLE): back-to-back operation.
- Carry preset: 1 for SUB/SLT/SLTU, 0 otherwise. B is inverted bitwise for SUB/SLT/SLTU.
- OP encoding:
  - 000 ADD; 001 SUB; 010 AND; 011 OR; 100 XOR; 101 NOR.
  - 110/111: see Optional Feature.
- Arithmetic wraps modulo 2^WIDTH; there is no overflow flag.
- Y, CARRY and ZERO change only on the completion edge or on reset. Inputs A, B and OP may change freely after capture.

Optional Feature:
- Macro: SERIAL_ALU_COMPARE_EN.
- Defined:
  - OP 110 = SLT (signed): runs A-B serially; Y = {0.., lt}, lt = (A_msb != B_msb) ? A_msb : diff_msb.
  - OP 111 = SLTU: lt = ~carry_out; Y = {0.., lt}.
  - CARRY=0 for both ops; ZERO reflects the final Y.
- Undefined: OP 110/111 run the full WIDTH cycles and produce Y=0, CARRY=0, ZERO=1, with a normal DONE pulse.

Test Plan (WIDTH=8):
- Reset: RST held 2 cycles with START=1 -> BUSY=0, DONE=0, Y=0x00, CARRY=0, ZERO=0 throughout; no operation starts.
- ADD: A=0xF0, B=0x25, OP=000, START at edge k -> BUSY high cycles k+1..k+8; DONE high only after edge k+8; Y=0x15, CARRY=1, ZERO=0.
- SUB and logic ops:
  - A=0x42, B=0x42, OP=001 -> Y=0x00, CARRY=1, ZERO=1.
  - NOR with A=0x0F, B=0x30 -> Y=0xC0, CARRY=0.
- Handshake: START pulsed at mid-RUN with new operands -> ignored, first result unchanged. START held high in the DONE cycle -> second operation starts; its DONE arrives exactly 9 cycles after the first.
- Abort: RST asserted at bit 4 of ADD 0x01+0x01 -> no DONE, Y=0x00. A following ADD 0x01+0x01 completes with Y=0x02.
- Compare:
  - Macro defined: SLT A=0xFE, B=0x01 -> Y=0x01; SLTU same operands -> Y=0x00.
  - Macro undefined: OP=110 -> Y=0x00, ZERO=1, DONE after 8 cycles.
